// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the psr-update predicate
// for the two-stage ALU pipeline.
package alu_pkg;

  localparam logic [4:0] OP_AND   = 5'b00001;
  localparam logic [4:0] OP_OR    = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_NOT   = 5'b00100;
  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_ADDU  = 5'b00110;
  localparam logic [4:0] OP_ADDC  = 5'b00111;
  localparam logic [4:0] OP_ADDCU = 5'b01111;
  localparam logic [4:0] OP_SUB   = 5'b01001;
  localparam logic [4:0] OP_CMP   = 5'b01011;
  localparam logic [4:0] OP_LSH   = 5'b01100;
  localparam logic [4:0] OP_RSH   = 5'b10011;
  localparam logic [4:0] OP_ARSH  = 5'b10111;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Only the flag-producing arithmetic ops are allowed to touch psr.
  function automatic logic sets_psr(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe; master = requester, slave = ALU.
interface alu_pipe_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [4:0]       in_opcode;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic [4:0]       out_flags;
  logic             out_err;
  logic [4:0]       psr;

  modport master (
    output in_valid, in_a, in_b, in_opcode, in_cin, out_ready,
    input  in_ready, out_valid, out_c, out_flags, out_err, psr
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, in_cin, out_ready,
    output in_ready, out_valid, out_c, out_flags, out_err, psr
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath sitting between the two pipeline registers.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] c,
  output logic [4:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic             big;
  logic             carry_in;

  always_comb begin
    c        = '0;
    flags    = '0;
    err      = 1'b0;
    sum      = '0;
    sh       = b[SHW-1:0];
    // any bit above the shift field means the amount is >= WIDTH
    big      = |b[WIDTH-1:SHW];
    carry_in = ((opcode == OP_ADDC) || (opcode == OP_ADDCU)) ? cin : 1'b0;
    case (opcode)
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_XOR: c = a ^ b;
      OP_NOT: c = ~a;
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
        c   = sum[WIDTH-1:0];
        if ((opcode == OP_ADD) || (opcode == OP_ADDC)) begin
          flags[FLAG_C] = sum[WIDTH];
          flags[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
          flags[FLAG_Z] = (c == '0);
          flags[FLAG_N] = c[WIDTH-1];
        end
      end
      OP_SUB: begin
        c             = a - b;
        flags[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
        flags[FLAG_Z] = (c == '0);
        flags[FLAG_N] = c[WIDTH-1];
      end
      OP_CMP: begin
        flags[FLAG_Z] = (a == b);
        flags[FLAG_N] = ($signed(a) < $signed(b));
        flags[FLAG_L] = (a < b);
      end
      OP_LSH:  c = big ? '0 : (a << sh);
      OP_RSH:  c = big ? '0 : (a >> sh);
      OP_ARSH: c = big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> sh);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register, alu_core, result register,
// plus a sticky psr loaded when a flag-setting result is consumed.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [4:0]       s1_op;
  logic             s1_cin;
  logic             s1_psr_upd;

  logic [WIDTH-1:0] core_c;
  logic [4:0]       core_flags;
  logic             core_err;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_c_q;
  logic [4:0]       out_flags_q;
  logic             out_err_q;
  logic             s2_psr_upd;
  logic [4:0]       psr_q;

  logic             s2_free;
  logic             s1_adv;
  logic             in_ready_w;

  // in_ready depends only on registered state and out_ready, never on in_valid
  assign s2_free    = !out_valid_q || bus.out_ready;
  assign s1_adv     = s1_valid && s2_free;
  assign in_ready_w = !s1_valid || s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_cin     <= 1'b0;
      s1_psr_upd <= 1'b0;
    end else if (in_ready_w) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a       <= bus.in_a;
        s1_b       <= bus.in_b;
        s1_op      <= bus.in_opcode;
        s1_cin     <= bus.in_cin;
        s1_psr_upd <= sets_psr(bus.in_opcode);
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .cin    (s1_cin),
    .c      (core_c),
    .flags  (core_flags),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_flags_q <= '0;
      out_err_q   <= 1'b0;
      s2_psr_upd  <= 1'b0;
      psr_q       <= '0;
    end else begin
      if (s2_free) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_c_q     <= core_c;
          out_flags_q <= core_flags;
          out_err_q   <= core_err;
          s2_psr_upd  <= s1_psr_upd;
        end
      end
      if (out_valid_q && bus.out_ready && s2_psr_upd)
        psr_q <= out_flags_q;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_err   = out_err_q;
  assign bus.psr       = psr_q;

endmodule
